// File: rtl/clock_set_ctrl_if.sv
// Time/date edit bus: buttons and running BCD value in, edited BCD value and
// display hints out of the edit controller.
interface clock_set_ctrl_if;
    logic       btn_set;
    logic       btn_next;
    logic       btn_inc;

    logic [3:0] cur_sec_unit;
    logic [3:0] cur_sec_ten;
    logic [3:0] cur_min_unit;
    logic [3:0] cur_min_ten;
    logic [3:0] cur_hour_unit;
    logic [3:0] cur_hour_ten;
    logic [3:0] cur_day_unit;
    logic [1:0] cur_day_ten;
    logic [3:0] cur_month_unit;
    logic [1:0] cur_month_ten;
    logic [3:0] cur_year_unit;
    logic [3:0] cur_year_ten;
    logic [3:0] cur_year_hund;
    logic [3:0] cur_year_thou;

    logic [3:0] set_sec_unit;
    logic [3:0] set_sec_ten;
    logic [3:0] set_min_unit;
    logic [3:0] set_min_ten;
    logic [3:0] set_hour_unit;
    logic [3:0] set_hour_ten;
    logic [3:0] set_day_unit;
    logic [1:0] set_day_ten;
    logic [3:0] set_month_unit;
    logic [1:0] set_month_ten;
    logic [3:0] set_year_unit;
    logic [3:0] set_year_ten;
    logic [3:0] set_year_hund;
    logic [3:0] set_year_thou;

    logic       set_load;
    logic       editing;
    logic [2:0] field;
    logic       blink;

    modport master (
        input  btn_set, btn_next, btn_inc,
        input  cur_sec_unit, cur_sec_ten, cur_min_unit, cur_min_ten,
        input  cur_hour_unit, cur_hour_ten, cur_day_unit, cur_day_ten,
        input  cur_month_unit, cur_month_ten,
        input  cur_year_unit, cur_year_ten, cur_year_hund, cur_year_thou,
        output set_sec_unit, set_sec_ten, set_min_unit, set_min_ten,
        output set_hour_unit, set_hour_ten, set_day_unit, set_day_ten,
        output set_month_unit, set_month_ten,
        output set_year_unit, set_year_ten, set_year_hund, set_year_thou,
        output set_load, editing, field, blink
    );

    modport slave (
        output btn_set, btn_next, btn_inc,
        output cur_sec_unit, cur_sec_ten, cur_min_unit, cur_min_ten,
        output cur_hour_unit, cur_hour_ten, cur_day_unit, cur_day_ten,
        output cur_month_unit, cur_month_ten,
        output cur_year_unit, cur_year_ten, cur_year_hund, cur_year_thou,
        input  set_sec_unit, set_sec_ten, set_min_unit, set_min_ten,
        input  set_hour_unit, set_hour_ten, set_day_unit, set_day_ten,
        input  set_month_unit, set_month_ten,
        input  set_year_unit, set_year_ten, set_year_hund, set_year_thou,
        input  set_load, editing, field, blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Century-clock edit controller: captures the running time/date, lets the user
// step and increment fields, and commits the result with a one-cycle load.
module clock_set_ctrl #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    clock_set_ctrl_if.master bus
);
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t           state, state_nxt;
    logic             set_q, next_q, inc_q;
    logic             set_e, next_e, inc_e;
    logic             capture, do_next, do_inc, do_commit;
    logic             set_load_q, editing_q, blink_q;
    logic [2:0]       field_q;
    logic [CNT_W-1:0] blink_cnt;

    logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, dy_u, mo_u;
    logic [1:0] dy_t, mo_t;
    logic [3:0] yr_th, yr_h, yr_t, yr_u;

    logic [6:0] yy, cc, mo_bin, day_bin, dim_bin;
    logic       leap;
    logic [1:0] dim_t;
    logic [3:0] dim_u;

    // Rising-edge detect with set > next > inc priority
    assign set_e  = bus.btn_set & ~set_q;
    assign next_e = bus.btn_next & ~next_q & ~set_e;
    assign inc_e  = bus.btn_inc & ~inc_q & ~set_e & ~(bus.btn_next & ~next_q);

    // Days in the month currently held in the shadow registers
    always_comb begin
        yy      = 7'(yr_t) * 7'd10 + 7'(yr_u);
        cc      = 7'(yr_th) * 7'd10 + 7'(yr_h);
        mo_bin  = 7'(mo_t) * 7'd10 + 7'(mo_u);
        day_bin = 7'(dy_t) * 7'd10 + 7'(dy_u);
        leap    = (yy != 7'd0) ? (yy[1:0] == 2'd0) : (cc[1:0] == 2'd0);
        dim_t   = 2'd3;
        dim_u   = 4'd1;
        case (mo_bin)
            7'd2: begin
                dim_t = 2'd2;
                dim_u = leap ? 4'd9 : 4'd8;
            end
            7'd4, 7'd6, 7'd9, 7'd11: begin
                dim_t = 2'd3;
                dim_u = 4'd0;
            end
            default: ;
        endcase
        dim_bin = 7'(dim_t) * 7'd10 + 7'(dim_u);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        do_next   = 1'b0;
        do_inc    = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                if (set_e) begin
                    state_nxt = EDIT;
                    capture   = 1'b1;
                end
            end
            EDIT: begin
                if (set_e) begin
                    state_nxt = COMMIT;
                    do_commit = 1'b1;
                end else if (next_e) begin
                    do_next = 1'b1;
                end else if (inc_e) begin
                    do_inc = 1'b1;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q <= 1'b0; next_q <= 1'b0; inc_q <= 1'b0;
            set_load_q <= 1'b0; editing_q <= 1'b0; blink_q <= 1'b1;
            field_q <= 3'd0; blink_cnt <= '0;
            hr_t <= 4'd0; hr_u <= 4'd0; mn_t <= 4'd0; mn_u <= 4'd0;
            sc_t <= 4'd0; sc_u <= 4'd0; dy_t <= 2'd0; dy_u <= 4'd1;
            mo_t <= 2'd0; mo_u <= 4'd1;
            yr_th <= 4'd2; yr_h <= 4'd0; yr_t <= 4'd0; yr_u <= 4'd0;
        end else begin
            set_q      <= bus.btn_set;
            next_q     <= bus.btn_next;
            inc_q      <= bus.btn_inc;
            set_load_q <= (state_nxt == COMMIT);
            editing_q  <= (state_nxt == EDIT);

            // Blink restarts on every user action so the edited field stays visible
            if (capture || do_next || do_inc || (state_nxt != EDIT)) begin
                blink_q   <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                blink_q   <= ~blink_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end

            if (capture) begin
                field_q <= 3'd0;
                hr_t <= bus.cur_hour_ten;   hr_u <= bus.cur_hour_unit;
                mn_t <= bus.cur_min_ten;    mn_u <= bus.cur_min_unit;
                sc_t <= bus.cur_sec_ten;    sc_u <= bus.cur_sec_unit;
                dy_t <= bus.cur_day_ten;    dy_u <= bus.cur_day_unit;
                mo_t <= bus.cur_month_ten;  mo_u <= bus.cur_month_unit;
                yr_th <= bus.cur_year_thou; yr_h <= bus.cur_year_hund;
                yr_t <= bus.cur_year_ten;   yr_u <= bus.cur_year_unit;
            end

            if (do_next) field_q <= (field_q == 3'd5) ? 3'd0 : field_q + 3'd1;

            if (do_commit && (day_bin > dim_bin)) begin
                dy_t <= dim_t;
                dy_u <= dim_u;
            end

            if (do_inc) begin
                case (field_q)
                    3'd0: begin
                        if (hr_t == 4'd2 && hr_u == 4'd3) begin hr_t <= 4'd0; hr_u <= 4'd0; end
                        else if (hr_u == 4'd9) begin hr_t <= hr_t + 4'd1; hr_u <= 4'd0; end
                        else hr_u <= hr_u + 4'd1;
                    end
                    3'd1: begin
                        if (mn_u == 4'd9) begin
                            mn_u <= 4'd0;
                            mn_t <= (mn_t == 4'd5) ? 4'd0 : mn_t + 4'd1;
                        end else mn_u <= mn_u + 4'd1;
                    end
                    3'd2: begin
                        if (sc_u == 4'd9) begin
                            sc_u <= 4'd0;
                            sc_t <= (sc_t == 4'd5) ? 4'd0 : sc_t + 4'd1;
                        end else sc_u <= sc_u + 4'd1;
                    end
                    3'd3: begin
                        if (day_bin >= dim_bin) begin dy_t <= 2'd0; dy_u <= 4'd1; end
                        else if (dy_u == 4'd9) begin dy_t <= dy_t + 2'd1; dy_u <= 4'd0; end
                        else dy_u <= dy_u + 4'd1;
                    end
                    3'd4: begin
                        if (mo_bin == 7'd12) begin mo_t <= 2'd0; mo_u <= 4'd1; end
                        else if (mo_u == 4'd9) begin mo_t <= 2'd1; mo_u <= 4'd0; end
                        else mo_u <= mo_u + 4'd1;
                    end
                    3'd5: begin
                        if (yr_u != 4'd9) yr_u <= yr_u + 4'd1;
                        else begin
                            yr_u <= 4'd0;
                            if (yr_t != 4'd9) yr_t <= yr_t + 4'd1;
                            else begin
                                yr_t <= 4'd0;
                                if (yr_h != 4'd9) yr_h <= yr_h + 4'd1;
                                else begin
                                    yr_h  <= 4'd0;
                                    yr_th <= (yr_th == 4'd9) ? 4'd0 : yr_th + 4'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.set_hour_ten   = hr_t;
    assign bus.set_hour_unit  = hr_u;
    assign bus.set_min_ten    = mn_t;
    assign bus.set_min_unit   = mn_u;
    assign bus.set_sec_ten    = sc_t;
    assign bus.set_sec_unit   = sc_u;
    assign bus.set_day_ten    = dy_t;
    assign bus.set_day_unit   = dy_u;
    assign bus.set_month_ten  = mo_t;
    assign bus.set_month_unit = mo_u;
    assign bus.set_year_thou  = yr_th;
    assign bus.set_year_hund  = yr_h;
    assign bus.set_year_ten   = yr_t;
    assign bus.set_year_unit  = yr_u;
    assign bus.set_load       = set_load_q;
    assign bus.editing        = editing_q;
    assign bus.field          = field_q;
    assign bus.blink          = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus randomized edit sessions
// checked against an integer calendar model.
module tb_clock_set_ctrl;
    localparam int unsigned BLINK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int load_cnt = 0;
    int m_hour, m_min, m_sec, m_day, m_month, m_year, m_field, m_edit;
    int c_hour, c_min, c_sec, c_day, c_month, c_year;

    always @(negedge clk) if (bus.set_load === 1'b1) load_cnt++;

    function automatic bit is_leap(input int y);
        int yy = y % 100;
        int cc = y / 100;
        return (yy != 0) ? (yy % 4 == 0) : (cc % 4 == 0);
    endfunction

    function automatic int days_in(input int mo, input int y);
        case (mo)
            2:             return is_leap(y) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic logic [55:0] bcd_pack(input int h, mi, s, d, mo, y);
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
                4'(d / 10), 4'(d % 10), 4'(mo / 10), 4'(mo % 10),
                4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
    endfunction

    function automatic logic [55:0] exp_pack();
        return bcd_pack(m_hour, m_min, m_sec, m_day, m_month, m_year);
    endfunction

    function automatic logic [55:0] dut_pack();
        return {bus.set_hour_ten, bus.set_hour_unit, bus.set_min_ten, bus.set_min_unit,
                bus.set_sec_ten, bus.set_sec_unit, 2'b00, bus.set_day_ten, bus.set_day_unit,
                2'b00, bus.set_month_ten, bus.set_month_unit, bus.set_year_thou,
                bus.set_year_hund, bus.set_year_ten, bus.set_year_unit};
    endfunction

    task automatic mdl_reset();
        m_hour = 0; m_min = 0; m_sec = 0; m_day = 1; m_month = 1; m_year = 2000;
        m_field = 0; m_edit = 0;
    endtask

    // Expected effect of one button press (rising edges all in one cycle)
    task automatic mdl_apply(input bit s, input bit n, input bit i);
        if (m_edit == 0) begin
            if (s) begin
                m_hour = c_hour; m_min = c_min; m_sec = c_sec;
                m_day = c_day; m_month = c_month; m_year = c_year;
                m_field = 0; m_edit = 1;
            end
        end else if (s) begin
            if (m_day > days_in(m_month, m_year)) m_day = days_in(m_month, m_year);
            m_edit = 0;
        end else if (n) begin
            m_field = (m_field + 1) % 6;
        end else if (i) begin
            case (m_field)
                0: m_hour = (m_hour + 1) % 24;
                1: m_min = (m_min + 1) % 60;
                2: m_sec = (m_sec + 1) % 60;
                3: m_day = (m_day >= days_in(m_month, m_year)) ? 1 : m_day + 1;
                4: m_month = m_month % 12 + 1;
                default: m_year = (m_year + 1) % 10000;
            endcase
        end
    endtask

    task automatic drive_cur(input int h, mi, s, d, mo, y);
        c_hour = h; c_min = mi; c_sec = s; c_day = d; c_month = mo; c_year = y;
        bus.cur_hour_ten   = 4'(h / 10);  bus.cur_hour_unit  = 4'(h % 10);
        bus.cur_min_ten    = 4'(mi / 10); bus.cur_min_unit   = 4'(mi % 10);
        bus.cur_sec_ten    = 4'(s / 10);  bus.cur_sec_unit   = 4'(s % 10);
        bus.cur_day_ten    = 2'(d / 10);  bus.cur_day_unit   = 4'(d % 10);
        bus.cur_month_ten  = 2'(mo / 10); bus.cur_month_unit = 4'(mo % 10);
        bus.cur_year_thou  = 4'(y / 1000);
        bus.cur_year_hund  = 4'((y / 100) % 10);
        bus.cur_year_ten   = 4'((y / 10) % 10);
        bus.cur_year_unit  = 4'(y % 10);
    endtask

    // Raise the chosen buttons together, hold them, release; returns on a negedge
    task automatic press(input bit s, input bit n, input bit i, input int hold);
        @(negedge clk);
        bus.btn_set = s; bus.btn_next = n; bus.btn_inc = i;
        repeat (hold) @(negedge clk);
        bus.btn_set = 1'b0; bus.btn_next = 1'b0; bus.btn_inc = 1'b0;
    endtask

    task automatic do_op(input bit s, input bit n, input bit i, input int hold);
        press(s, n, i, hold);
        mdl_apply(s, n, i);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.editing, bus.set_load, bus.blink, bus.field} !== 6'b001_000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got edit=%b load=%b blink=%b field=%0d, need 0 0 1 0",
                     bus.editing, bus.set_load, bus.blink, bus.field);
        end
        n_cmp++;
        if (dut_pack() !== bcd_pack(0, 0, 0, 1, 1, 2000)) begin
            n_bad++;
            $display("FAIL reset_value: got %h need %h", dut_pack(), bcd_pack(0, 0, 0, 1, 1, 2000));
        end
    endtask

    task automatic test_capture();
        drive_cur(13, 45, 30, 5, 7, 2024);
        do_op(1'b0, 1'b1, 1'b1, 1);
        n_cmp++;
        if (bus.editing !== 1'b0 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL idle_ignore: got edit=%b val=%h need 0 %h", bus.editing, dut_pack(), exp_pack());
        end
        do_op(1'b1, 1'b0, 1'b0, 1);
        n_cmp++;
        if ({bus.editing, bus.blink, bus.field} !== 5'b11_000 || load_cnt != 0) begin
            n_bad++;
            $display("FAIL capture_ctrl: got edit=%b blink=%b field=%0d loads=%0d need 1 1 0 0",
                     bus.editing, bus.blink, bus.field, load_cnt);
        end
        n_cmp++;
        if (dut_pack() !== bcd_pack(13, 45, 30, 5, 7, 2024)) begin
            n_bad++;
            $display("FAIL capture_value: got %h need %h", dut_pack(), bcd_pack(13, 45, 30, 5, 7, 2024));
        end
        do_op(1'b1, 1'b0, 1'b0, 1);
        n_cmp++;
        if (bus.set_load !== 1'b1 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL capture_commit: got load=%b val=%h need 1 %h", bus.set_load, dut_pack(), exp_pack());
        end
    endtask

    task automatic test_wrap_time();
        drive_cur(23, 14, 59, 10, 3, 2023);
        do_op(1'b1, 1'b0, 1'b0, 1);
        do_op(1'b0, 1'b0, 1'b1, 1);
        n_cmp++;
        if ({bus.set_hour_ten, bus.set_hour_unit} !== 8'h00 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL hour_wrap: got %h need %h", dut_pack(), exp_pack());
        end
        do_op(1'b0, 1'b1, 1'b0, 1);
        do_op(1'b0, 1'b1, 1'b0, 1);
        do_op(1'b0, 1'b0, 1'b1, 1);
        n_cmp++;
        if ({bus.set_sec_ten, bus.set_sec_unit, bus.set_min_ten, bus.set_min_unit} !== 16'h0014
            || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL sec_wrap: got %h need %h", dut_pack(), exp_pack());
        end
        repeat (4) do_op(1'b0, 1'b1, 1'b0, 1);
        repeat (6) do_op(1'b0, 1'b1, 1'b0, 1);
        n_cmp++;
        if (bus.field !== 3'd0 || m_field != 0) begin
            n_bad++;
            $display("FAIL field_wrap: got field=%0d need 0", bus.field);
        end
        do_op(1'b1, 1'b0, 1'b0, 1);
    endtask

    task automatic test_feb_clamp();
        int years[3] = '{1900, 2000, 2024};
        int want[3]  = '{28, 29, 29};
        int lc;
        for (int k = 0; k < 3; k++) begin
            drive_cur(8, 0, 0, 31, 1, years[k]);
            do_op(1'b1, 1'b0, 1'b0, 1);
            repeat (4) do_op(1'b0, 1'b1, 1'b0, 1);
            do_op(1'b0, 1'b0, 1'b1, 1);
            lc = load_cnt;
            do_op(1'b1, 1'b0, 1'b0, 1);
            n_cmp++;
            if (bus.set_load !== 1'b1 || int'(bus.set_day_ten) * 10 + int'(bus.set_day_unit) != want[k]
                || dut_pack() !== exp_pack()) begin
                n_bad++;
                $display("FAIL feb_clamp_%0d: got load=%b val=%h need 1 %h", years[k], bus.set_load,
                         dut_pack(), exp_pack());
            end
            repeat (2) @(negedge clk);
            n_cmp++;
            if (load_cnt - lc != 1 || bus.editing !== 1'b0) begin
                n_bad++;
                $display("FAIL load_once_%0d: got %0d pulses edit=%b need 1 0", years[k], load_cnt - lc, bus.editing);
            end
        end
    endtask

    task automatic test_year_day_wrap();
        drive_cur(12, 0, 0, 30, 4, 9999);
        do_op(1'b1, 1'b0, 1'b0, 1);
        repeat (3) do_op(1'b0, 1'b1, 1'b0, 1);
        do_op(1'b0, 1'b0, 1'b1, 1);
        n_cmp++;
        if ({bus.set_day_ten, bus.set_day_unit} !== 6'h01 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL day_wrap: got %h need %h", dut_pack(), exp_pack());
        end
        repeat (2) do_op(1'b0, 1'b1, 1'b0, 1);
        do_op(1'b0, 1'b0, 1'b1, 1);
        n_cmp++;
        if ({bus.set_year_thou, bus.set_year_hund, bus.set_year_ten, bus.set_year_unit} !== 16'h0000
            || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL year_wrap: got %h need %h", dut_pack(), exp_pack());
        end
        do_op(1'b1, 1'b0, 1'b0, 1);
    endtask

    task automatic test_hold_priority();
        drive_cur(7, 20, 5, 15, 6, 2031);
        do_op(1'b1, 1'b0, 1'b0, 1);
        do_op(1'b0, 1'b0, 1'b1, 100);
        n_cmp++;
        if (dut_pack() !== exp_pack() || m_hour != 8) begin
            n_bad++;
            $display("FAIL hold_once: got %h need %h", dut_pack(), exp_pack());
        end
        do_op(1'b0, 1'b1, 1'b1, 1);
        n_cmp++;
        if (bus.field !== 3'd1 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL next_over_inc: got field=%0d val=%h need 1 %h", bus.field, dut_pack(), exp_pack());
        end
        do_op(1'b1, 1'b0, 1'b1, 1);
        n_cmp++;
        if (bus.set_load !== 1'b1 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL set_over_inc: got load=%b val=%h need 1 %h", bus.set_load, dut_pack(), exp_pack());
        end
    endtask

    task automatic test_blink();
        int errs = 0;
        drive_cur(1, 2, 3, 4, 5, 2006);
        do_op(1'b1, 1'b0, 1'b0, 1);
        for (int k = 0; k < 13; k++) begin
            if (bus.blink !== ((k / BLINK_DIV) % 2 == 0)) errs++;
            @(negedge clk);
        end
        do_op(1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 9; k++) begin
            if (bus.blink !== ((k / BLINK_DIV) % 2 == 0)) errs++;
            if (k < 8) @(negedge clk);
        end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL blink_phase: got %0d wrong cycles need 0", errs);
        end
    endtask

    task automatic test_reset_mid_edit();
        int lc;
        do_op(1'b0, 1'b0, 1'b1, 1);
        lc = load_cnt;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        mdl_reset();
        n_cmp++;
        if (bus.editing !== 1'b0 || bus.field !== 3'd0 || bus.set_load !== 1'b0 || dut_pack() !== exp_pack()) begin
            n_bad++;
            $display("FAIL reset_mid_edit: got edit=%b field=%0d val=%h need 0 0 %h", bus.editing,
                     bus.field, dut_pack(), exp_pack());
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (load_cnt != lc || bus.editing !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_load: got %0d pulses edit=%b need 0 0", load_cnt - lc, bus.editing);
        end
    endtask

    task automatic test_random();
        int y, mo, nops, r, lc;
        bit nb, ib;
        for (int s = 0; s < 25; s++) begin
            y  = $urandom_range(9999);
            mo = $urandom_range(12, 1);
            drive_cur($urandom_range(23), $urandom_range(59), $urandom_range(59),
                      $urandom_range(days_in(mo, y), 1), mo, y);
            @(negedge clk);
            n_cmp++;
            if (dut_pack() !== exp_pack()) begin
                n_bad++;
                $display("FAIL rnd_idle_hold %0d: got %h need %h", s, dut_pack(), exp_pack());
            end
            do_op(1'b1, 1'b0, 1'b0, $urandom_range(3, 1));
            nops = $urandom_range(14, 4);
            for (int o = 0; o < nops; o++) begin
                r  = $urandom_range(9);
                nb = (r < 4);
                ib = (r >= 3);
                do_op(1'b0, nb, ib, $urandom_range(4, 1));
                n_cmp++;
                if (bus.editing !== 1'b1 || int'(bus.field) != m_field || dut_pack() !== exp_pack()) begin
                    n_bad++;
                    $display("FAIL rnd_edit %0d.%0d: got field=%0d val=%h need %0d %h", s, o,
                             bus.field, dut_pack(), m_field, exp_pack());
                end
            end
            lc = load_cnt;
            do_op(1'b1, 1'b0, 1'b0, 1);
            n_cmp++;
            if (bus.set_load !== 1'b1 || dut_pack() !== exp_pack()) begin
                n_bad++;
                $display("FAIL rnd_commit %0d: got load=%b val=%h need 1 %h", s, bus.set_load,
                         dut_pack(), exp_pack());
            end
            repeat (2) @(negedge clk);
            n_cmp++;
            if (load_cnt - lc != 1 || bus.editing !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_load_once %0d: got %0d pulses need 1", s, load_cnt - lc);
            end
        end
    endtask

    initial begin
        bus.btn_set = 1'b0; bus.btn_next = 1'b0; bus.btn_inc = 1'b0;
        drive_cur(0, 0, 0, 1, 1, 2000);
        mdl_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_capture();
        test_wrap_time();
        test_feb_clamp();
        test_year_day_wrap();
        test_hold_priority();
        test_random();
        test_blink();
        test_reset_mid_edit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time/date edit controller for the century clock. It is the writer side of the BCD time/date bus that the display path reads. It captures the running time/date, lets the user walk the fields and increment them with push-buttons, then commits the edited value back to the counter chain with a one-cycle load pulse. While editing, it also supplies the selected-field index and a blink phase so the display can flash the field being edited.

Parameters:
BLINK_DIV, 25000000, clk cycles per blink half-period (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_set  in  1  set/commit button, level, already debounced and synchronous to clk
btn_next  in  1  next-field button, level, debounced, synchronous
btn_inc  in  1  increment button, level, debounced, synchronous
cur_sec_unit, cur_sec_ten, cur_min_unit, cur_min_ten, cur_hour_unit, cur_hour_ten  in  4 each  running time, BCD
cur_day_unit  in  4;  cur_day_ten  in  2;  cur_month_unit  in  4;  cur_month_ten  in  2  running date, BCD
cur_year_unit, cur_year_ten, cur_year_hund, cur_year_thou  in  4 each  running year, BCD
set_sec_unit … set_year_thou  out  widths identical to the matching cur_* port  edited value
set_load  out  1  one-cycle pulse; counter chain loads set_* on this cycle
editing  out  1  high while in EDIT
field  out  3  selected field: 0 HOUR, 1 MIN, 2 SEC, 3 DAY, 4 MONTH, 5 YEAR
blink  out  1  1 = show the selected field, 0 = blank it

Behaviour:
- Reset (async, rst_n=0): state IDLE; set_* = 00:00:00, 01/01/2000; set_load=0; editing=0; field=0; blink=1; blink counter=0; button history regs=0.
- Each button is edge-detected on the rising edge using a registered previous value. An action fires the cycle after the edge is sampled. Holding a button produces exactly one action.
- Same-cycle edges are prioritised set > next > inc. Lower-priority edges are discarded.
- FSM states: IDLE, EDIT, COMMIT.
- IDLE: editing=0, blink=1, set_* hold their last values.
  - On a set edge, shadow regs <- cur_*, field <- 0, go to EDIT.
  - next and inc edges are ignored.
- EDIT: editing=1.
  - next edge: field <- field+1; after 5 it wraps to 0.
  - inc edge: increment the selected field in BCD, with these wraps:
    - HOUR 23->00.
    - MIN/SEC 59->00.
    - DAY max(month,year)->01. Days per month are 31/28/30 by the usual table, and February is 29 in a leap year.
    - MONTH 12->01.
    - YEAR 9999->0000, with full 4-digit BCD carry.
  - Incrementing MONTH or YEAR does not change the day.
  - set edge: go to COMMIT.
- COMMIT (one cycle):
  - If the day exceeds the maximum for the current month/year, day <- that maximum.
  - set_load=1 for exactly this cycle, with set_* already holding the final value.
  - Next state is IDLE.
- Leap year: YY = ten*10+unit, CC = thou*10+hund. Leap if (YY != 0 and YY%4 == 0) or (YY == 0 and CC%4 == 0).
- Blink:
  - The counter runs only in EDIT. blink toggles when the counter reaches BLINK_DIV-1, and the counter then clears.
  - Entering EDIT, or any next/inc action, forces blink=1 and clears the counter.
- set_* must always hold legal BCD. Every digit is ≤9, and the ten-fields stay within their ranges (day_ten ≤3, month_ten ≤1, hour_ten ≤2).
- If rst_n asserts mid-edit, the block returns to IDLE immediately and no set_load is emitted.
- The cur_* inputs are sampled only on the IDLE->EDIT transition.

Test Plan:
1. Reset, then cur=13:45:30 05/07/2024, pulse btn_set -> editing=1, field=0, blink=1, set_*=13:45:30 05/07/2024; no set_load.
2. In EDIT field 0 from 23h, pulse btn_inc -> hour 00. Press btn_next twice, then btn_inc from sec 59 -> sec 00, min unchanged. Pressing btn_next 6 times from field 0 returns field=0.
3. Date 31/01/1900, edit MONTH to 02, commit -> set_load one cycle with day=28 (1900 is not a leap year). Repeat with 2000 -> day=29. Repeat with 2024 -> 29.
4. YEAR 9999 + inc -> 0000. DAY 30 in month 04 + inc -> 01.
5. Hold btn_inc high for 100 cycles -> exactly one increment. Raise btn_next and btn_inc in the same cycle -> field advances and the value is unchanged.
6. BLINK_DIV=4: blink toggles every 4 cycles in EDIT and resets to 1 on an inc action. Assert rst_n=0 mid-edit -> editing=0, field=0, set_*=00:00:00 01/01/2000, no set_load.
